// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the MMIO UART transmitter: bus addresses, STATUS layout, serializer states.
// The optional occupancy field (STATUS[23:16]) is enabled with UART_TX_LEVEL_EN.
package mmio_uart_tx_pkg;

  localparam logic [31:0] HALT_ADDR        = 32'hf000_0000;
  localparam logic [31:0] UART_TXDATA_ADDR = 32'hf000_0100;
  localparam logic [31:0] UART_STATUS_ADDR = 32'hf000_0104;

  localparam int unsigned STATUS_DRAINED_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT    = 1;
  localparam int unsigned STATUS_OVF_BIT     = 8;
  localparam int unsigned STATUS_LEVEL_LSB   = 16;
  localparam int unsigned STATUS_LEVEL_W     = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] status_word(input logic drained, input logic full,
                                              input logic ovf,
                                              input logic [STATUS_LEVEL_W-1:0] level);
    logic [31:0] w;
    w = '0;
    w[STATUS_DRAINED_BIT] = drained;
    w[STATUS_FULL_BIT]    = full;
    w[STATUS_OVF_BIT]     = ovf;
    w[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = level;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Circular synchronous FIFO with extra-MSB pointers; pushes when full and pops when empty are ignored.
// The occupancy counter behind o_level exists only when UART_TX_LEVEL_EN is defined.
module mmio_uart_tx_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic                w_push_ok;
  logic                w_pop_ok;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign o_rdata = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wdata;
  end

`ifdef UART_TX_LEVEL_EN
  logic [DEPTH_LOG2:0] r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level <= '0;
    end else begin
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_level = r_level;
`else
  assign o_level = '0;
`endif

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, TX FIFO and registered serializer.
// Define UART_TX_LEVEL_EN to expose FIFO occupancy in STATUS[23:16].
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT    = 868,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter logic [31:0] BASE_ADDR       = UART_TXDATA_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_oe,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        uart_tx
);

  localparam int unsigned   DivW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DivW-1:0] DivMax    = DivW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;

  logic                     w_hit;
  logic                     w_rd;
  logic                     w_push_req;
  logic                     w_push;
  logic                     w_ovf_set;
  logic                     w_status_rd;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [7:0]               w_fifo_rdata;
  logic [FIFO_DEPTH_LOG2:0] w_level;
  logic [31:0]              w_rdata_d;
  logic                     w_unused_wdata;

  logic                     r_ready;
  logic [31:0]              r_rdata;
  logic                     r_ovf;

  tx_state_e                r_state;
  tx_state_e                w_state_d;
  logic [DivW-1:0]          r_div;
  logic [DivW-1:0]          w_div_d;
  logic                     w_div_done;
  logic [2:0]               r_bit;
  logic [2:0]               w_bit_d;
  logic [7:0]               r_shift;
  logic [7:0]               w_shift_d;
  logic                     r_tx;
  logic                     w_tx_d;

  assign w_unused_wdata = ^mem_wdata[31:8];

  assign w_hit       = mem_oe && (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign w_rd        = w_hit && (mem_we == 4'b0000);
  assign w_push_req  = w_hit && (mem_we != 4'b0000) && mem_we[0] && (mem_addr == BASE_ADDR);
  // Full is sampled before the serializer's same-cycle pop, so a push into a full FIFO drops.
  assign w_push      = w_push_req && !w_full;
  assign w_ovf_set   = w_push_req && w_full;
  assign w_status_rd = w_rd && (mem_addr == STATUS_ADDR);
  assign w_pop       = (r_state == StIdle) && !w_empty;

  mmio_uart_tx_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata (mem_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_rdata_d = '0;
    if (w_rd) begin
      if (mem_addr == BASE_ADDR) begin
        w_rdata_d = {31'd0, !w_full};
      end else if (mem_addr == STATUS_ADDR) begin
        w_rdata_d = status_word(w_empty && (r_state == StIdle), w_full, r_ovf,
                                STATUS_LEVEL_W'(w_level));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ready <= w_rd;
      r_rdata <= w_rdata_d;
      r_ovf   <= (r_ovf && !w_status_rd) || w_ovf_set;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_div   <= w_div_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;
    end
  end

  assign w_div_done = (r_div == DivMax);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (!w_empty) w_state_d = StStart;
      StStart: if (w_div_done) w_state_d = StData;
      StData:  if (w_div_done && (r_bit == 3'd7)) w_state_d = StStop;
      StStop:  if (w_div_done) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // uart_tx is computed from the next state so the registered pin changes on the transition edge.
  always_comb begin
    w_div_d   = (w_state_d != r_state || w_div_done) ? '0 : r_div + DivW'(1);
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    if (w_pop) begin
      w_shift_d = w_fifo_rdata;
      w_bit_d   = 3'd0;
    end else if (r_state == StData && w_div_done) begin
      w_bit_d   = r_bit + 3'd1;
      w_shift_d = {1'b0, r_shift[7:1]};
    end
    unique case (w_state_d)
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_shift_d[0];
      default: w_tx_d = 1'b1;
    endcase
  end

  assign uart_tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed timing checks plus randomized traffic
// decoded back from the TX pin by a UART receiver model.
module tb_mmio_uart_tx;

  localparam int unsigned C   = 4;
  localparam int unsigned DL2 = 4;
  localparam logic [31:0] TXD = 32'hf000_0100;
  localparam logic [31:0] STS = 32'hf000_0104;
`ifdef UART_TX_LEVEL_EN
  localparam bit LvlEn = 1'b1;
`else
  localparam bit LvlEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_oe = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_we = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        uart_tx;

  int n_cmp = 0;
  int n_fail = 0;
  int n_frame_err = 0;
  bit mon_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .CLKS_PER_BIT    (C),
    .FIFO_DEPTH_LOG2 (DL2),
    .BASE_ADDR       (TXD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_oe    (mem_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .uart_tx   (uart_tx)
  );

  // Receiver model: samples each bit near its middle, independent of the DUT internals.
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (mon_en && uart_tx === 1'b0) begin
      b = '0;
      repeat (C / 2) @(negedge clk);
      if (uart_tx !== 1'b0) n_frame_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (C) @(negedge clk);
      if (uart_tx !== 1'b1) n_frame_err++;
      rx_q.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic oe, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] d);
    @(negedge clk);
    mem_oe    = oe;
    mem_addr  = a;
    mem_we    = we;
    mem_wdata = d;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, output logic [31:0] d);
    drive(1'b1, a, 4'b0000, 32'h0);
    drive(1'b0, 32'h0, 4'b0000, 32'h0);
    check({tag, "_ready"}, mem_ready, 1'b1);
    d = mem_rdata;
  endtask

  function automatic logic [31:0] st(input bit drained, input bit full, input bit ovf,
                                     input int lvl);
    logic [31:0] w;
    w = '0;
    w[0] = drained;
    w[1] = full;
    w[8] = ovf;
    if (LvlEn) w[23:16] = 8'(lvl);
    return w;
  endfunction

  // Expected pin level j cycles after the write-accept edge: 1 idle, C start, 8*C data, stop.
  function automatic logic frame_bit(input logic [7:0] byt, input int j);
    if (j < 1) return 1'b1;
    if (j < 1 + int'(C)) return 1'b0;
    if (j < 1 + 9 * int'(C)) return byt[(j - 1 - int'(C)) / int'(C)];
    return 1'b1;
  endfunction

  task automatic wait_drain(input string tag);
    logic [31:0] d;
    int i;
    d = '0;
    i = 0;
    while (!d[0] && i < 1500) begin
      bus_read("drain_poll", STS, d);
      i++;
    end
    check({tag, "_drained"}, d[0], 1'b1);
  endtask

  task automatic compare_rx(input string tag);
    int n;
    check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_rx_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] r;
    logic [3:0]  we;
    int          op;
    int          pushes;
    int          lows;

    repeat (3) @(negedge clk);
    check("reset_tx", uart_tx, 1'b1);
    check("reset_ready", mem_ready, 1'b0);
    check("reset_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    bus_read("status_after_reset", STS, d);
    check("status_after_reset", d, st(1, 0, 0, 0));

    // Single byte, exact pin timing relative to the accept edge.
    drive(1'b1, TXD, 4'b0001, 32'h0000_0041);
    exp_q.push_back(8'h41);
    drive(1'b0, 32'h0, 4'b0000, 32'h0);
    check("write_no_ready", mem_ready, 1'b0);
    for (int j = 0; j < 48; j++) begin
      if (j > 0) @(negedge clk);
      check("frame41", uart_tx, frame_bit(8'h41, j));
    end
    wait_drain("single");
    compare_rx("single");

    // Fill: first byte pops immediately, 16 more fit, the 18th overflows.
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, TXD, 4'b0001, 32'(i));
      if (i < 17) exp_q.push_back(8'(i));
    end
    bus_read("txdata_full", TXD, d);
    check("txdata_full", d, 32'h0);
    bus_read("status_ovf", STS, d);
    check("status_ovf", d, st(0, 1, 1, 16));
    bus_read("status_ovf_clr", STS, d);
    check("status_ovf_clr", d, st(0, 1, 0, 16));
    repeat (25) @(negedge clk);
    bus_read("txdata_avail", TXD, d);
    check("txdata_avail", d, 32'h1);
    wait_drain("fill");
    compare_rx("fill");

    // Decode edges.
    bus_read("other_in_window", TXD + 32'd8, d);
    check("other_in_window", d, 32'h0);
    @(negedge clk);
    check("ready_one_cycle", mem_ready, 1'b0);
    drive(1'b1, 32'h0000_1000, 4'b0000, 32'h0);
    drive(1'b0, 32'h0, 4'b0000, 32'h0);
    check("outside_ready", mem_ready, 1'b0);
    check("outside_rdata", mem_rdata, 32'h0);

    // Randomized mix of real pushes and writes that must be ignored.
    pushes = 0;
    for (int k = 0; k < 28; k++) begin
      op = $urandom_range(0, 3);
      d  = $urandom;
      if (op < 2 && pushes >= 16) op = 3;
      if (op < 2) begin
        we = 4'($urandom_range(0, 15)) | 4'b0001;
        drive(1'b1, TXD, we, d);
        exp_q.push_back(d[7:0]);
        pushes++;
      end else if (op == 2) begin
        we = 4'($urandom_range(1, 15));
        drive(1'b1, STS, we, d);
      end else begin
        we = 4'($urandom_range(1, 7)) << 1;
        drive(1'b1, TXD, we, d);
      end
      repeat ($urandom_range(0, 3)) drive(1'b0, 32'h0, 4'b0000, 32'h0);
    end
    bus_read("rand_status", STS, r);
    check("rand_no_ovf", r & 32'h0000_0102, 32'h0);
    wait_drain("rand");
    compare_rx("rand");

    // Occupancy while the serializer is busy with the first byte.
    drive(1'b1, TXD, 4'b0001, 32'h11);
    drive(1'b0, 32'h0, 4'b0000, 32'h0);
    drive(1'b0, 32'h0, 4'b0000, 32'h0);
    drive(1'b1, TXD, 4'b0001, 32'h22);
    drive(1'b1, TXD, 4'b0001, 32'h33);
    drive(1'b1, TXD, 4'b0001, 32'h44);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    bus_read("status_level", STS, d);
    check("status_level", d, st(0, 0, 0, 3));
    wait_drain("level");
    compare_rx("level");

    // Reset mid-DATA with another byte still queued.
    mon_en = 1'b0;
    drive(1'b1, TXD, 4'b0001, 32'h00);
    drive(1'b1, TXD, 4'b0001, 32'h00);
    drive(1'b0, 32'h0, 4'b0000, 32'h0);
    repeat (12) @(negedge clk);
    check("pre_rst_tx", uart_tx, 1'b0);
    #2 rst = 1'b1;
    #1 check("rst_async_tx", uart_tx, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus_read("status_post_rst", STS, d);
    check("status_post_rst", d, st(1, 0, 0, 0));
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("no_frame_after_rst", lows, 0);
    check("frame_errors", n_frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor data bus (mem_oe/mem_addr/mem_wdata/mem_we/mem_rdata/mem_ready), in the 0xf0000100 MMIO window.
- Replaces the ideal console model with real hardware: write FIFO, status registers and an 8N1 serializer driving a TX pin.
- Its mem_ready/mem_rdata are ORed/muxed with dmem_ready/dmem_rdata at the top level, like every other bus slave.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (≥2).
- FIFO_DEPTH_LOG2, 4, log2 of TX FIFO entries (16).
- BASE_ADDR, 32'hf0000100, address of TXDATA; STATUS is at BASE_ADDR+4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mem_oe  in  1  bus request strobe, one cycle per request
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_we  in  4  byte write enables; 0 = read
- mem_rdata  out  32  read data, valid while mem_ready=1
- mem_ready  out  1  read response strobe
- uart_tx  out  1  serial output, idle high

Behaviour:
- Reset: async on rst. uart_tx=1, mem_ready=0, mem_rdata=0, FIFO empty, overflow sticky=0, serializer IDLE, bit counter and divider=0.
- Decode: hit = mem_oe && mem_addr[31:8]==BASE_ADDR[31:8]. Outside the window the block drives mem_ready=0 and mem_rdata=0.
- Writes (hit, mem_we!=0):
  - TXDATA with mem_we[0]=1: push mem_wdata[7:0].
  - Push into a full FIFO (full sampled before any same-cycle pop): data dropped, overflow sticky set.
  - All other write addresses and byte lanes are ignored.
  - Writes never assert mem_ready.
- Reads (hit, mem_we==0): mem_ready=1 exactly one cycle later, for one cycle, with mem_rdata:
  - TXDATA: 32'h1 if FIFO not full, else 0. This is the console "TX available" poll.
  - STATUS: bit0 = FIFO empty && serializer IDLE (drained); bit1 = FIFO full; bit8 = overflow sticky; others 0. Overflow is cleared on the cycle this read is accepted; an overflow arriving in that same cycle wins.
  - Any other address in the window: 0.
- No pipelining: one outstanding request, and a request is accepted every cycle.
- FIFO: circular, FIFO_DEPTH_LOG2+1-bit pointers, wrap-around by natural overflow. full = pointer MSBs differ and the rest are equal. A simultaneous push and pop on a non-full, non-empty FIFO keeps the level constant.
- Serializer FSM:
  - IDLE: uart_tx=1. If FIFO non-empty, pop into the shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; a 3-bit counter; after bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back bytes: IDLE lasts exactly one cycle between frames. The frame period is 10*CLKS_PER_BIT+1 cycles.
- Latency: write accepted at edge N → FIFO non-empty after N → pop at edge N+1 → uart_tx falls after edge N+1.
- The divider counts 0..CLKS_PER_BIT-1 and resets on every state change.
- uart_tx is registered, so there are no glitches.
- rst mid-frame: uart_tx returns to 1 immediately. The FIFO contents and the in-flight byte are discarded.

Optional Feature:
- Macro UART_TX_LEVEL_EN.
- Defined: STATUS bits [23:16] return the current FIFO occupancy (0..2^FIFO_DEPTH_LOG2, zero-extended). An occupancy counter is maintained alongside the pointers.
- Undefined: bits [23:16] read 0 and no counter is synthesized.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package/include (next to INST.v):
  - MMIO address constants: HALT 32'hf0000000, UART_TXDATA 32'hf0000100, UART_STATUS 32'hf0000104.
  - STATUS bit-position constants.
  - Serializer state encodings (IDLE/START/DATA/STOP, 2 bits).
- One sub-module: sync_fifo (parameterized width and depth, push/pop/full/empty/level), which is reusable for a future RX path.

Test Plan:
- CLKS_PER_BIT=4. Write 0x41 to 0xf0000100 at edge N:
  - uart_tx=0 during cycles N+2..N+5;
  - data bits 1,0,0,0,0,0,1,0 for 4 cycles each;
  - stop bit high;
  - back to IDLE, with uart_tx continuously high from N+42 on.
- 17 writes (0x00..0x10) with FIFO_DEPTH_LOG2=4 in consecutive cycles:
  - the first byte is popped at once, so 16 writes fit; expect no overflow;
  - an 18th write sets STATUS bit8;
  - reading STATUS returns bit8=1, and the next read returns bit8=0.
- Read 0xf0000100 while the FIFO is full → mem_ready one cycle later with mem_rdata=0. After one pop, the same read → 1.
- Read 0xf0000108 → mem_ready=1, mem_rdata=0. Read 0x00001000 → mem_ready stays 0.
- Assert rst mid-DATA for 1 cycle → uart_tx=1 asynchronously; STATUS read afterwards = 32'h1 (drained); no further frame is emitted.
- With UART_TX_LEVEL_EN and 3 queued bytes while the serializer is busy → STATUS[23:16]=3.
